rf_multiport: RTL and testbench

Parametrised register file: one write port, two independent combinational read ports, optional write-to-read bypass, and a hardware clear sequencer with a busy/done handshake. It sits in the datapath where operand pairs are read in one cycle, and replaces the fixed 4x8 single-port register file in new designs. Depth and width are generic. The clear sequencer zeroes the array without a global reset.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_clr_seq.sv | 73 +++++++
 rtl/rf_multiport.sv | 101 ++++++++++
 tb/tb_rf_multiport.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and limits for the multiport register file and its clear sequencer.
package rf_pkg;

    // Clear sequencer states.
    typedef enum logic [1:0] {
        RF_CLR_IDLE,
        RF_CLR_CLEAR,
        RF_CLR_DONE
    } rf_clr_state_t;

    // Largest supported number of entries.
    localparam int RF_MAX_DEPTH = 256;

endpackage

// File: rtl/rf_clr_seq.sv
// Clear sequencer: walks an index across every entry, one per cycle, asking the
// array to zero it, then emits a single-cycle done pulse before returning to idle.
module rf_clr_seq
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_busy,
    output logic              clr_done
);

    // Termination compares against the last real entry, so non-power-of-two
    // depths stop exactly at DEPTH-1 and the index never wraps.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_clr_state_t     state;
    rf_clr_state_t     state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    // State and index registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_CLR_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state, index update and handshake outputs.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        clr_we     = 1'b0;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        case (state)
            RF_CLR_IDLE: begin
                if (clr_req) begin
                    state_next = RF_CLR_CLEAR;
                    idx_next   = '0;
                end
            end
            RF_CLR_CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = RF_CLR_DONE;
                end else begin
                    idx_next = idx + ADDR_W'(1);
                end
            end
            RF_CLR_DONE: begin
                clr_done   = 1'b1;
                state_next = RF_CLR_IDLE;
            end
            default: begin
                state_next = RF_CLR_IDLE;
            end
        endcase
    end

    assign clr_addr = idx;

endmodule

// File: rtl/rf_multiport.sv
// Register file with one write port, two combinational read ports, optional
// same-cycle write forwarding, and a hardware clear sequencer.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    output logic [DATA_W-1:0] RD_DATA_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [DATA_W-1:0] RD_DATA_B,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    output logic              CLR_DONE
);

    if (DEPTH < 2 || DEPTH > RF_MAX_DEPTH) begin : g_bad_depth
        $error("rf_multiport: DEPTH out of range");
    end

    // One extra bit so the range check works even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_busy;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rd_a_ok;
    logic              rd_b_ok;

    rf_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr_req  (CLR_REQ),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_busy (clr_busy),
        .clr_done (CLR_DONE)
    );

    assign CLR_BUSY = clr_busy;

    // External writes are locked out while clearing and silently dropped when
    // they address a non-existent entry.
    assign wr_ok   = WR_EN && !clr_busy && ({1'b0, WR_ADDR} < DEPTH_V);
    assign rd_a_ok = {1'b0, RD_ADDR_A} < DEPTH_V;
    assign rd_b_ok = {1'b0, RD_ADDR_B} < DEPTH_V;

    // The clear sequencer owns the array port while busy and writes zeros.
    assign mem_we   = clr_we || wr_ok;
    assign mem_addr = clr_we ? clr_addr : WR_ADDR;
    assign mem_data = clr_we ? '0 : WR_DATA;

    // Storage array; asynchronously zeroed on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Read port A: forwarded write data, live entry, or zero when out of range.
    always_comb begin
        RD_DATA_A = '0;
        if (BYPASS != 0 && wr_ok && WR_ADDR == RD_ADDR_A) begin
            RD_DATA_A = WR_DATA;
        end else if (rd_a_ok) begin
            RD_DATA_A = mem[RD_ADDR_A];
        end
    end

    // Read port B: same selection as port A on its own address.
    always_comb begin
        RD_DATA_B = '0;
        if (BYPASS != 0 && wr_ok && WR_ADDR == RD_ADDR_B) begin
            RD_DATA_B = WR_DATA;
        end else if (rd_b_ok) begin
            RD_DATA_B = mem[RD_ADDR_B];
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: a DEPTH=4 bypass build, a DEPTH=4 no-bypass
// build sharing its inputs, and a DEPTH=5 build with its own inputs.
module tb_rf_multiport;

    logic       clk = 1'b0;
    logic       rst_n;

    // Shared inputs for the two DEPTH=4 instances.
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       clr_req;

    logic [7:0] a_rda, a_rdb, n_rda, n_rdb;
    logic       a_busy, a_done, n_busy, n_done;

    // DEPTH=5 instance signals.
    logic       c_wr_en;
    logic [2:0] c_wr_addr;
    logic [7:0] c_wr_data;
    logic [2:0] c_ra;
    logic [2:0] c_rb;
    logic       c_clr_req;
    logic [7:0] c_rda, c_rdb;
    logic       c_busy, c_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_multiport #(.DATA_W(8), .DEPTH(4), .BYPASS(1)) u_a (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .RD_ADDR_A(ra), .RD_DATA_A(a_rda), .RD_ADDR_B(rb), .RD_DATA_B(a_rdb),
        .CLR_REQ(clr_req), .CLR_BUSY(a_busy), .CLR_DONE(a_done)
    );

    rf_multiport #(.DATA_W(8), .DEPTH(4), .BYPASS(0)) u_n (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .RD_ADDR_A(ra), .RD_DATA_A(n_rda), .RD_ADDR_B(rb), .RD_DATA_B(n_rdb),
        .CLR_REQ(clr_req), .CLR_BUSY(n_busy), .CLR_DONE(n_done)
    );

    rf_multiport #(.DATA_W(8), .DEPTH(5), .BYPASS(1)) u_c (
        .CLK(clk), .RST_N(rst_n), .WR_EN(c_wr_en), .WR_ADDR(c_wr_addr), .WR_DATA(c_wr_data),
        .RD_ADDR_A(c_ra), .RD_DATA_A(c_rda), .RD_ADDR_B(c_rb), .RD_DATA_B(c_rdb),
        .CLR_REQ(c_clr_req), .CLR_BUSY(c_busy), .CLR_DONE(c_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;   // expected port A, bypass build
        logic [7:0] eb;   // expected port B, bypass build
        logic [7:0] na;   // expected port A, no-bypass build
        logic [7:0] nb;   // expected port B, no-bypass build
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nbusy;
        int ndone;
        logic seen;

        //              we    wa    wd     ra    rb    ea     eb     na     nb
        vecs[0] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 2'd2, 8'hA5, 2'd2, 2'd1, 8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 2'd1, 8'h3C, 2'd2, 2'd1, 8'hA5, 8'h3C, 8'hA5, 8'h00};
        vecs[3] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[4] = '{1'b1, 2'd3, 8'h11, 2'd3, 2'd3, 8'h11, 8'h11, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 2'd3, 8'h77, 2'd3, 2'd0, 8'h77, 8'h00, 8'h11, 8'h00};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 8'h77, 8'hA5, 8'h77, 8'hA5};

        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; ra = '0; rb = '0; clr_req = 1'b0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_ra = '0; c_rb = '0; c_clr_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_done", 32'(a_done), 32'd0);
        chk("reset_c_rd", 32'(c_rda), 32'd0);

        // Write/read and bypass vectors.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_byp_a", i), 32'(a_rda), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_byp_b", i), 32'(a_rdb), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_nob_a", i), 32'(n_rda), 32'(vecs[i].na));
            chk($sformatf("vec%0d_nob_b", i), 32'(n_rdb), 32'(vecs[i].nb));
        end

        // Fill 1..4 then clear, with a dropped write mid-sequence.
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 2'(e); wr_data = 8'(e + 1);
        end
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            clr_req = 1'b0;
            ra = (j < 4) ? 2'(j) : 2'd3;
            rb = (j == 0) ? 2'd0 : ((j > 4) ? 2'd3 : 2'(j - 1));
            wr_en = (j == 1); wr_addr = 2'd0; wr_data = 8'hFF;
            #1;
            chk($sformatf("clr%0d_busy", j), 32'(a_busy), 32'(j < 4));
            chk($sformatf("clr%0d_done", j), 32'(a_done), 32'(j == 4));
            chk($sformatf("clr%0d_rda", j), 32'(a_rda), (j < 4) ? 32'(j + 1) : 32'd0);
            chk($sformatf("clr%0d_rdb", j), 32'(a_rdb), (j == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        wr_en = 1'b0; ra = 2'd0;
        #1;
        chk("clr_drop_entry0", 32'(a_rda), 32'd0);
        chk("clr_nob_entry0", 32'(n_rda), 32'd0);

        // Reset during CLEAR index 1.
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 2'(e); wr_data = 8'(e + 1);
        end
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_abort_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0; ra = 2'd3; rb = 2'd2;
        #1;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_rda", 32'(a_rda), 32'd0);
        chk("abort_rdb", 32'(a_rdb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (a_done || a_busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // A fresh request after the abort completes normally.
        @(negedge clk);
        clr_req = 1'b1;
        nbusy = 0; seen = 1'b0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            clr_req = 1'b0;
            if (a_busy) nbusy++;
            if (a_done) seen = 1'b1;
        end
        chk("restart_busy_cycles", 32'(nbusy), 32'd4);
        chk("restart_done_seen", 32'(seen), 32'd1);

        // Held request: period of busy x4, done, one idle cycle.
        @(negedge clk);
        clr_req = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("b2b%0d", j), 32'({a_busy, a_done}),
                32'({((j % 6) < 4), ((j % 6) == 4)}));
        end
        clr_req = 1'b0;
        repeat (8) @(negedge clk);

        // DEPTH=5: out-of-range write and read, then a five-entry clear.
        c_wr_en = 1'b1; c_wr_addr = 3'd7; c_wr_data = 8'h5A; c_ra = 3'd7; c_rb = 3'd6;
        #1;
        chk("d5_oor_rda", 32'(c_rda), 32'd0);
        chk("d5_oor_rdb", 32'(c_rdb), 32'd0);
        @(negedge clk);
        c_wr_addr = 3'd6; c_wr_data = 8'h5A;
        @(negedge clk);
        c_wr_addr = 3'd4; c_wr_data = 8'h44; c_ra = 3'd4; c_rb = 3'd6;
        #1;
        chk("d5_byp4", 32'(c_rda), 32'h44);
        chk("d5_rd6", 32'(c_rdb), 32'd0);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            c_wr_en = 1'b0; c_ra = 3'(e);
            #1;
            chk($sformatf("d5_entry%0d", e), 32'(c_rda), 32'd0);
        end
        @(negedge clk);
        c_ra = 3'd4;
        #1;
        chk("d5_entry4", 32'(c_rda), 32'h44);
        c_clr_req = 1'b1;
        nbusy = 0; seen = 1'b0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            c_clr_req = 1'b0;
            if (c_busy) nbusy++;
            if (c_done) seen = 1'b1;
        end
        chk("d5_busy_cycles", 32'(nbusy), 32'd5);
        chk("d5_done_seen", 32'(seen), 32'd1);
        #1;
        chk("d5_entry4_cleared", 32'(c_rda), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
